// File: rtl/timer_scheduler_pkg.sv
// rtl/timer_scheduler_pkg.sv - shared types and default rates for the timer scheduler
package timer_sched_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  localparam int DEF_FPGA_RATE = 50_000_000;
  localparam int DEF_TICK_RATE = 1000;
  localparam int DEF_NCH       = 4;
  localparam int DEF_PERIOD_W  = 8;

  // Event id width; a single-channel build still carries a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// rtl/timer_scheduler_if.sv - expiry event handshake between scheduler and consumer
interface timer_scheduler_if #(
  parameter int NCH = timer_sched_pkg::DEF_NCH
);
  localparam int ID_W = timer_sched_pkg::id_width(NCH);

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/timer_scheduler_tick_gen.sv
// rtl/timer_scheduler_tick_gen.sv - shared prescaler producing a one-cycle timebase tick
module tick_gen
  import timer_sched_pkg::*;
#(
  parameter int FPGA_RATE = DEF_FPGA_RATE,
  parameter int TICK_RATE = DEF_TICK_RATE
) (
  input  logic fpga_clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int PRESCALE = (FPGA_RATE / TICK_RATE > 0) ? FPGA_RATE / TICK_RATE : 1;
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge fpga_clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - NCH timers on a shared tick with round-robin expiry events
// Optional auto-reload: define TIMER_SCHED_RELOAD_EN.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int FPGA_RATE = DEF_FPGA_RATE,
  parameter int TICK_RATE = DEF_TICK_RATE,
  parameter int NCH       = DEF_NCH,
  parameter int PERIOD_W  = DEF_PERIOD_W
) (
  input  logic                    fpga_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NCH-1:0]          start,
  input  logic [NCH-1:0]          stop,
  input  logic [NCH*PERIOD_W-1:0] period,
  input  logic [NCH-1:0]          reload,
  output logic                    tick,
  output logic [NCH-1:0]          busy,
  output logic [NCH-1:0]          overrun,
  timer_scheduler_if.master       evt
);

  localparam int ID_W = id_width(NCH);

  ch_state_e           state_q [NCH];
  ch_state_e           state_d [NCH];
  logic [PERIOD_W-1:0] rem_q   [NCH];
  logic [PERIOD_W-1:0] rem_d   [NCH];
  logic [PERIOD_W-1:0] ch_period;

  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  overrun_q, overrun_d;
  logic [NCH-1:0]  expiry, start_acc, clr, reload_en;
  logic [ID_W-1:0] last_grant_q, held_id_q, rr_id, sel_id, idx_l;
  logic            held_q, rr_found, evt_fire;
  int              idx;

`ifdef TIMER_SCHED_RELOAD_EN
  assign reload_en = reload;
`else
  logic unused_reload;
  assign unused_reload = ^reload;
  assign reload_en     = '0;
`endif

  tick_gen #(
    .FPGA_RATE (FPGA_RATE),
    .TICK_RATE (TICK_RATE)
  ) u_tick_gen (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .enable   (enable),
    .tick     (tick)
  );

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    rr_id    = '0;
    rr_found = 1'b0;
    idx      = 0;
    idx_l    = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx   = (int'(last_grant_q) + k) % NCH;
      idx_l = ID_W'(idx);
      if (!rr_found && pending_q[idx_l]) begin
        rr_found = 1'b1;
        rr_id    = idx_l;
      end
    end
  end

  // A stalled event keeps its id even if a higher-priority channel expires meanwhile.
  assign sel_id        = held_q ? held_id_q : rr_id;
  assign evt.evt_valid = |pending_q;
  assign evt.evt_id    = sel_id;
  assign evt_fire      = evt.evt_valid && evt.evt_ready;

  always_comb begin
    clr = '0;
    if (evt_fire) begin
      clr[sel_id] = 1'b1;
    end
  end

  always_comb begin
    expiry    = '0;
    start_acc = '0;
    ch_period = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      ch_period  = period[i*PERIOD_W +: PERIOD_W];
      if (stop[i]) begin
        state_d[i] = CH_IDLE;
        rem_d[i]   = '0;
      end else if (start[i] && (ch_period != '0)) begin
        start_acc[i] = 1'b1;
        state_d[i]   = CH_RUN;
        rem_d[i]     = ch_period;
      end else if ((state_q[i] == CH_RUN) && tick) begin
        if (rem_q[i] == PERIOD_W'(1)) begin
          expiry[i] = 1'b1;
          if (reload_en[i] && (ch_period != '0)) begin
            rem_d[i] = ch_period;
          end else begin
            state_d[i] = CH_IDLE;
            rem_d[i]   = '0;
          end
        end else begin
          rem_d[i] = rem_q[i] - PERIOD_W'(1);
        end
      end
    end
    // An expiry landing on the cycle its old event is accepted is not an overrun.
    pending_d = (pending_q & ~clr) | expiry;
    overrun_d = (overrun_q | (expiry & pending_q & ~clr)) & ~start_acc;
  end

  always_ff @(posedge fpga_clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= CH_IDLE;
        rem_q[i]   <= '0;
      end
      pending_q    <= '0;
      overrun_q    <= '0;
      last_grant_q <= ID_W'(NCH - 1);
      held_q       <= 1'b0;
      held_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      held_q    <= evt.evt_valid && !evt.evt_ready;
      held_id_q <= sel_id;
      if (evt_fire) begin
        last_grant_q <= sel_id;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (state_q[i] == CH_RUN);
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed vectors, corner sequences and random run against a reference model
module tb_timer_scheduler;

  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int P   = 10;
`ifdef TIMER_SCHED_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  logic        fpga_clk = 1'b0;
  logic        rst, enable, tick;
  logic [3:0]  start, stop, reload, busy, overrun;
  logic [31:0] period;

  timer_scheduler_if #(.NCH(NCH)) evt_if ();

  timer_scheduler #(
    .FPGA_RATE (100),
    .TICK_RATE (10),
    .NCH       (NCH),
    .PERIOD_W  (PW)
  ) dut (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .period   (period),
    .reload   (reload),
    .tick     (tick),
    .busy     (busy),
    .overrun  (overrun),
    .evt      (evt_if.master)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    while (tick !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    chk("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  typedef struct {
    bit        tk;
    bit [3:0]  st;
    bit [3:0]  sp;
    bit [31:0] per;
    bit        rdy;
    bit        rstn;
    bit [3:0]  e_busy;
    bit        e_valid;
    bit [1:0]  e_id;
    bit [3:0]  e_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit tk, bit [3:0] st, bit [3:0] sp, bit [31:0] per, bit rdy,
                              bit rstn, bit [3:0] eb, bit ev, bit [1:0] eid, bit [3:0] eo);
    vec_t v;
    v = '{tk, st, sp, per, rdy, rstn, eb, ev, eid, eo};
    tbl.push_back(v);
  endfunction

  // Reference model: counts and flags per channel, updated once per clock edge.
  int m_pc, m_lg, m_hid;
  int m_rem [NCH];
  bit m_run [NCH];
  bit m_pend[NCH];
  bit m_ovr [NCH];
  bit m_held;

  function automatic bit m_valid();
    bit v;
    v = 1'b0;
    for (int c = 0; c < NCH; c++) v |= m_pend[c];
    return v;
  endfunction

  function automatic int m_id();
    if (m_held) return m_hid;
    for (int k = 1; k <= NCH; k++)
      if (m_pend[(m_lg + k) % NCH]) return (m_lg + k) % NCH;
    return 0;
  endfunction

  task automatic model_step();
    bit tk, v, hs, ex, cl;
    int g, p;
    if (!rst) begin
      m_pc = 0; m_lg = NCH - 1; m_held = 1'b0; m_hid = 0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_rem[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
      end
      return;
    end
    tk = enable && (m_pc == P - 1);
    v  = m_valid();
    g  = m_id();
    hs = v && evt_if.evt_ready;
    for (int c = 0; c < NCH; c++) begin
      ex = 1'b0;
      p  = int'(period[c*PW +: PW]);
      if (stop[c]) m_run[c] = 1'b0;
      else if (start[c] && p != 0) begin
        m_run[c] = 1'b1; m_rem[c] = p; m_ovr[c] = 1'b0;
      end else if (m_run[c] && tk) begin
        if (m_rem[c] == 1) begin
          ex = 1'b1;
          if (RELOAD_EN && reload[c] && p != 0) m_rem[c] = p;
          else m_run[c] = 1'b0;
        end else m_rem[c]--;
      end
      cl = hs && (g == c);
      if (ex && m_pend[c] && !cl) m_ovr[c] = 1'b1;
      m_pend[c] = (m_pend[c] && !cl) || ex;
    end
    m_held = v && !evt_if.evt_ready;
    m_hid  = g;
    if (hs) m_lg = g;
    if (enable) m_pc = (m_pc + 1) % P;
  endtask

  initial begin
    int first;
    bit [3:0] mb, mo;

    rst = 1'b0; enable = 1'b0; start = '0; stop = '0; reload = '0; period = '0;
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
    chk("rst_overrun", {28'd0, overrun}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);

    rst = 1'b1; enable = 1'b1;
    first = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (tick && first == 0) first = j;
    end
    chk("first_tick_edges", first, 9);

    // Round robin from reset (last_grant = 3), repeated.
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b1001, 4'b0, 32'h01000001, 1, 1, 4'b1001, 0, 0, 4'b0);
      add(1, 4'b0000, 4'b0, 32'h01000001, 1, 1, 4'b0000, 1, 0, 4'b0);
      add(0, 4'b0000, 4'b0, 32'h01000001, 1, 1, 4'b0000, 1, 3, 4'b0);
      add(0, 4'b0000, 4'b0, 32'h01000001, 1, 1, 4'b0000, 0, 0, 4'b0);
    end
    // One-shot ch0, period 3.
    add(0, 4'b0001, 4'b0, 32'h3, 1, 1, 4'b0001, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0, 32'h3, 1, 1, 4'b0001, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0, 32'h3, 1, 1, 4'b0001, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0, 32'h3, 1, 1, 4'b0000, 1, 0, 4'b0);
    add(0, 4'b0000, 4'b0, 32'h3, 1, 1, 4'b0000, 0, 0, 4'b0);
    // Stop ch2 after two ticks; later start+stop together.
    add(0, 4'b0100, 4'b0000, 32'h00050000, 1, 1, 4'b0100, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0000, 32'h00050000, 1, 1, 4'b0100, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0000, 32'h00050000, 1, 1, 4'b0100, 0, 0, 4'b0);
    add(0, 4'b0000, 4'b0100, 32'h00050000, 1, 1, 4'b0000, 0, 0, 4'b0);
    for (int r = 0; r < 3; r++)
      add(1, 4'b0000, 4'b0000, 32'h00050000, 1, 1, 4'b0000, 0, 0, 4'b0);
    add(0, 4'b0100, 4'b0100, 32'h00050000, 1, 1, 4'b0000, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0000, 32'h00050000, 1, 1, 4'b0000, 0, 0, 4'b0);
    // Period 0 ignored; reset drops a pending event.
    add(0, 4'b0010, 4'b0, 32'h0, 1, 1, 4'b0000, 0, 0, 4'b0);
    add(0, 4'b0001, 4'b0, 32'h1, 0, 1, 4'b0001, 0, 0, 4'b0);
    add(1, 4'b0000, 4'b0, 32'h1, 0, 1, 4'b0000, 1, 0, 4'b0);
    add(0, 4'b0000, 4'b0, 32'h1, 0, 1, 4'b0000, 1, 0, 4'b0);
    add(0, 4'b0000, 4'b0, 32'h1, 0, 0, 4'b0000, 0, 0, 4'b0);
    add(0, 4'b0000, 4'b0, 32'h1, 1, 1, 4'b0000, 0, 0, 4'b0);

    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rstn; enable = 1'b1; reload = '0;
      start = tbl[r].st; stop = tbl[r].sp; period = tbl[r].per;
      evt_if.evt_ready = tbl[r].rdy;
      if (tbl[r].tk) wait_tick();
      step();
      chk($sformatf("row%0d_busy", r), {28'd0, busy}, {28'd0, tbl[r].e_busy});
      chk($sformatf("row%0d_valid", r), {31'd0, evt_if.evt_valid}, {31'd0, tbl[r].e_valid});
      chk($sformatf("row%0d_overrun", r), {28'd0, overrun}, {28'd0, tbl[r].e_ovr});
      if (tbl[r].e_valid)
        chk($sformatf("row%0d_id", r), {30'd0, evt_if.evt_id}, {30'd0, tbl[r].e_id});
    end
    start = '0; stop = '0; rst = 1'b1;

    // Overrun set/clear, then expiry coinciding with acceptance.
    period = 32'h1; evt_if.evt_ready = 1'b0;
    start = 4'b0001; step(); start = '0;
    chk("ovr_busy", {28'd0, busy}, 32'd1);
    wait_tick(); step();
    chk("ovr_pend", {31'd0, evt_if.evt_valid}, 32'd1);
    start = 4'b0001; step(); start = '0;
    wait_tick(); step();
    chk("ovr_set", {28'd0, overrun}, 32'd1);
    start = 4'b0001; step(); start = '0;
    chk("ovr_clr_by_start", {28'd0, overrun}, 32'd0);
    wait_tick(); evt_if.evt_ready = 1'b1; step();
    chk("same_cycle_valid", {31'd0, evt_if.evt_valid}, 32'd1);
    chk("same_cycle_ovr", {28'd0, overrun}, 32'd0);
    step();
    chk("same_cycle_drain", {31'd0, evt_if.evt_valid}, 32'd0);

    // Reload on ch1, period 2, consumer stalled.
    period = 32'h00000200; reload = 4'b0010; evt_if.evt_ready = 1'b0;
    start = 4'b0010; step(); start = '0;
    chk("rl_busy", {28'd0, busy}, 32'h2);
    wait_tick(); step(); wait_tick(); step();
    chk("rl_valid", {31'd0, evt_if.evt_valid}, 32'd1);
    chk("rl_id", {30'd0, evt_if.evt_id}, 32'd1);
`ifdef TIMER_SCHED_RELOAD_EN
    chk("rl_busy_after", {28'd0, busy}, 32'h2);
    chk("rl_no_ovr", {28'd0, overrun}, 32'd0);
    wait_tick(); step(); wait_tick(); step();
    chk("rl_ovr", {28'd0, overrun}, 32'h2);
    chk("rl_still_busy", {28'd0, busy}, 32'h2);
    stop = 4'b0010; evt_if.evt_ready = 1'b1; step(); stop = '0; step();
    chk("rl_drain", {31'd0, evt_if.evt_valid}, 32'd0);
    chk("rl_stopped", {28'd0, busy}, 32'd0);
`else
    chk("oneshot_idle", {28'd0, busy}, 32'd0);
    wait_tick(); step(); wait_tick(); step();
    chk("oneshot_no_ovr", {28'd0, overrun}, 32'd0);
    evt_if.evt_ready = 1'b1; step();
    chk("oneshot_drain", {31'd0, evt_if.evt_valid}, 32'd0);
`endif

    // Random run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst    = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 9) != 0);
      for (int ch = 0; ch < NCH; ch++) begin
        start[ch]            = ($urandom_range(0, 11) == 0);
        stop[ch]             = ($urandom_range(0, 29) == 0);
        reload[ch]           = 1'($urandom_range(0, 1));
        period[ch*PW +: PW]  = 8'($urandom_range(0, 3));
      end
      evt_if.evt_ready = 1'($urandom_range(0, 1));
      model_step();
      step();
      for (int ch = 0; ch < NCH; ch++) begin
        mb[ch] = m_run[ch];
        mo[ch] = m_ovr[ch];
      end
      chk($sformatf("rnd%0d_busy", c), {28'd0, busy}, {28'd0, mb});
      chk($sformatf("rnd%0d_overrun", c), {28'd0, overrun}, {28'd0, mo});
      chk($sformatf("rnd%0d_valid", c), {31'd0, evt_if.evt_valid}, {31'd0, m_valid()});
      chk($sformatf("rnd%0d_tick", c), {31'd0, tick}, {31'd0, (enable && m_pc == P - 1)});
      if (m_valid())
        chk($sformatf("rnd%0d_id", c), {30'd0, evt_if.evt_id}, m_id());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter FPGA_RATE, default 50000000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_RATE, default 1000: shared timebase tick frequency in Hz.
REQ-003 SHALL have parameter NCH, default 4: number of timer channels sharing the timebase.
REQ-004 SHALL have parameter PERIOD_W, default 8: width of each channel period, in ticks.
REQ-005 SHALL have port fpga_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  global run; low freezes prescaler and all channel counts.
REQ-008 SHALL have port start  input  NCH  per-channel start/retrigger, sampled every cycle.
REQ-009 SHALL have port stop  input  NCH  per-channel abort, sampled every cycle.
REQ-010 SHALL have port period  input  NCH*PERIOD_W  per-channel period; channel i at bits [i*PERIOD_W +: PERIOD_W].
REQ-011 SHALL have port reload  input  NCH  per-channel auto-reload request.
REQ-012 SHALL have port tick  output  1  one-cycle timebase pulse.
REQ-013 SHALL have port busy  output  NCH  channel in RUN.
REQ-014 SHALL have ports evt_valid  output  1; evt_id  output  $clog2(NCH); evt_ready  input  1: expiry event handshake.
REQ-015 SHALL have port overrun  output  NCH  sticky: expiry while a previous event is still pending.

Function
REQ-016 SHALL define PRESCALE = FPGA_RATE/TICK_RATE; prescaler counts 0..PRESCALE-1 while enable=1 and wraps to 0; tick=1 exactly in the cycle the count equals PRESCALE-1 with enable=1.
REQ-017 Each channel SHALL be a two-state FSM, IDLE/RUN, with a PERIOD_W-bit remaining counter.
REQ-018 IDLE->RUN on start[i]=1 with period nonzero; busy[i]=1 and remaining=period in the next cycle; a start with period 0 SHALL be ignored.
REQ-019 In RUN, each tick SHALL decrement remaining; a tick with remaining==1 is an expiry.
REQ-020 On expiry, the channel SHALL set pending[i] next cycle; with reload[i]=1 it stays RUN with remaining=period, otherwise it returns to IDLE.
REQ-021 start[i] in RUN SHALL retrigger: remaining=period next cycle, and an expiry in that same cycle is discarded.
REQ-022 stop[i] SHALL force IDLE next cycle without an event; when stop and start coincide, stop wins.
REQ-023 Expiry while pending[i]=1 SHALL set overrun[i]; overrun[i] clears only on an accepted start[i] or on reset.
REQ-024 evt_valid SHALL equal OR of pending, combinationally from registers; evt_id = first pending index searched round-robin from last_grant+1.
REQ-025 When evt_valid and evt_ready are both 1, the handshake SHALL clear pending[evt_id] and set last_grant=evt_id; evt_id stays stable while evt_valid=1 and evt_ready=0.
REQ-026 Pending set and handshake clear on the same channel in the same cycle SHALL leave pending=1 and set overrun=0.
REQ-027 enable=0 SHALL freeze prescaler and remaining; start, stop and event handshake still operate.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL clear the prescaler, remaining, pending, overrun, tick, busy and evt_valid, set all FSMs to IDLE and set last_grant=NCH-1, so channel 0 wins first; reset mid-operation drops all pending events.

Configuration
REQ-029 SHALL honour macro TIMER_SCHED_RELOAD_EN: defined -> reload per REQ-020; undefined -> reload input ignored and all channels one-shot.

Structure
REQ-030 Package timer_sched_pkg SHALL hold the channel state enum and the default rate/width constants.
REQ-031 The prescaler SHALL be sub-module tick_gen, with ports fpga_clk, rst, enable and tick.

Verification (FPGA_RATE=100, TICK_RATE=10, PRESCALE=10)
REQ-032 Reset test: rst=0 for 3 cycles, then enable=1 -> all outputs 0, and the first tick appears on the 10th enabled cycle.
REQ-033 One-shot test: ch0 period=3, start pulse, evt_ready=1 -> busy[0] the next cycle; on the 3rd tick, evt_valid=1 with evt_id=0 the cycle after; busy[0]=0; event accepted in 1 cycle.
REQ-034 Reload/overrun test (macro defined): ch1 period=2, reload=1, evt_ready=0 -> pending after tick 2, overrun[1]=1 after tick 4, busy[1] stays 1.
REQ-035 Stop test: ch2 period=5, stop at tick 2 -> busy[2]=0 next cycle, no event, and start+stop in the same cycle keeps the channel IDLE.
REQ-036 Round-robin test: ch0 and ch3 period=1 expire on the same tick, evt_ready=1 -> evt_id 0 then 3 on consecutive cycles; a repeat gives 0 first again, since last_grant=3.
REQ-037 Corner test: start with period 0 -> busy stays 0; rst=0 mid-run with ch0 pending -> evt_valid=0 next cycle.
